// File: rtl/ha_reduce_pkg.sv
// Shared constants, group-sum container and the weighted reduction used by
// the half-adder array reduction pipeline.
package ha_reduce_pkg;

    localparam int NUM_GROUPS = 4;
    localparam int B_W        = 7;
    localparam int T_W        = 9;
    localparam int G_W        = 10;
    localparam int SUM_W      = 17;

    typedef struct packed {
        logic [NUM_GROUPS-1:0][G_W-1:0] g;
    } group_sums_t;

    // Group k carries weight 2^(2k) relative to group 0.
    function automatic logic [SUM_W-1:0] weighted_sum(input group_sums_t gs);
        logic [SUM_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < NUM_GROUPS; k++) begin
            acc = acc + ({{(SUM_W-G_W){1'b0}}, gs.g[k]} << (2 * k));
        end
        return acc;
    endfunction

endpackage

// File: rtl/ha_group_sum.sv
// Combinational sum of one half-adder group: top vector plus the bottom
// vector shifted up by two bit positions.
module ha_group_sum
    import ha_reduce_pkg::*;
(
    input  logic [B_W-1:0] b,
    input  logic [T_W-1:0] t,
    output logic [G_W-1:0] g
);

    assign g = {1'b0, t} + {1'b0, b, 2'b00};

endmodule

// File: rtl/ha_array_reduce_pipe.sv
// Two-stage valid/ready pipeline reducing four half-adder group vectors into
// a saturated 16-bit approximate product.
module ha_array_reduce_pipe
    import ha_reduce_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       ha_array_0_b,
    input  logic [6:0]       ha_array_1_b,
    input  logic [6:0]       ha_array_2_b,
    input  logic [6:0]       ha_array_3_b,
    input  logic [8:0]       ha_array_0_t,
    input  logic [8:0]       ha_array_1_t,
    input  logic [8:0]       ha_array_2_t,
    input  logic [8:0]       ha_array_3_t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] product,
    output logic             ovf
);

    logic [NUM_GROUPS-1:0][B_W-1:0] b_s;
    logic [NUM_GROUPS-1:0][T_W-1:0] t_s;
    logic [NUM_GROUPS-1:0][G_W-1:0] g_s;
    group_sums_t                    grp_s;
    logic [SUM_W-1:0]               sum_s;
    logic                           s1_adv_s;
    logic                           s2_adv_s;

    logic                           s1_valid_r;
    group_sums_t                    s1_grp_r;
    logic                           s2_valid_r;
    logic [OUT_W-1:0]               product_r;
    logic                           ovf_r;

    assign b_s = {ha_array_3_b, ha_array_2_b, ha_array_1_b, ha_array_0_b};
    assign t_s = {ha_array_3_t, ha_array_2_t, ha_array_1_t, ha_array_0_t};

    for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_group
        ha_group_sum u_group_sum (
            .b (b_s[k]),
            .t (t_s[k]),
            .g (g_s[k])
        );
    end

    // Gather group sums and derive the stage advance conditions.
    always_comb begin
        grp_s.g  = g_s;
        s2_adv_s = !s2_valid_r || out_ready;
        s1_adv_s = !s1_valid_r || s2_adv_s;
        sum_s    = weighted_sum(s1_grp_r);
    end

    assign in_ready = s1_adv_s;

    // Stage 1: capture group sums; bubbles clear valid but keep old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_grp_r   <= '0;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_grp_r <= grp_s;
            end
        end
    end

    // Stage 2: weighted reduction with saturation when bit 16 is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            product_r  <= '0;
            ovf_r      <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                product_r <= sum_s[SUM_W-1] ? {OUT_W{1'b1}} : sum_s[OUT_W-1:0];
                ovf_r     <= sum_s[SUM_W-1];
            end
        end
    end

    assign out_valid = s2_valid_r;
    assign product   = product_r;
    assign ovf       = ovf_r;

endmodule
